// File: rtl/regfile_write_ctrl_pkg.sv
// Shared widths and state encoding for the register-file write-channel arbiter.
package regfile_write_ctrl_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ROB_ADDR_WIDTH = 4;
    localparam int REG_COUNT      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WALK  = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_write_ctrl_commit_fifo.sv
// Synchronous FIFO of {addr,data} commit entries; head is visible combinationally.
module commit_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [AW-1:0] o_head_addr,
    output logic [DW-1:0] o_head_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [AW+DW-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage carries no reset; only the pointers define validity.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (i_push && (r_wr_ptr == PW'(gi))) begin
                r_mem[gi] <= {i_push_addr, i_push_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign {o_head_addr, o_head_data} = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/regfile_write_ctrl.sv
// Arbitrates the single register-file write port between rename, commit and flush restore walk.
module regfile_write_ctrl
    import regfile_write_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = regfile_write_ctrl_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = regfile_write_ctrl_pkg::REG_ADDR_WIDTH,
    parameter int ROB_ADDR_WIDTH = regfile_write_ctrl_pkg::ROB_ADDR_WIDTH,
    parameter int COMMIT_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_req,
    output logic                      flush_busy,
    input  logic                      commit_valid,
    output logic                      commit_ready,
    input  logic [REG_ADDR_WIDTH-1:0] commit_addr,
    input  logic [DATA_WIDTH-1:0]     commit_data,
    input  logic                      dispatch_valid,
    output logic                      dispatch_ready,
    input  logic [REG_ADDR_WIDTH-1:0] dispatch_addr,
    input  logic [ROB_ADDR_WIDTH-1:0] dispatch_rob_id,
    output logic                      rf_write_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
    output logic                      rf_write_restore,
    output logic                      rf_write_is_ref,
    output logic [DATA_WIDTH-1:0]     rf_write_data
);

    localparam int CW = $clog2(COMMIT_DEPTH) + 1;
    localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(REG_COUNT - 1);

    state_t                    r_state, w_state_next;
    logic [REG_ADDR_WIDTH-1:0] r_idx, w_idx_next;

    logic                      w_push, w_pop;
    logic                      w_fifo_full, w_fifo_empty;
    logic [CW-1:0]             w_fifo_count;
    logic [REG_ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0]     w_head_data;

    logic                      w_disp_rdy;
    logic                      w_en, w_restore, w_is_ref;
    logic [REG_ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]     w_data;

    assign w_push = commit_valid && commit_ready;

    commit_fifo #(
        .DEPTH (COMMIT_DEPTH),
        .AW    (REG_ADDR_WIDTH),
        .DW    (DATA_WIDTH)
    ) u_commit_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_addr (commit_addr),
        .i_push_data (commit_data),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= REG_ADDR_WIDTH'(1);
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_disp_rdy   = 1'b0;
        w_pop        = 1'b0;
        w_en         = 1'b0;
        w_restore    = 1'b0;
        w_is_ref     = 1'b0;
        w_addr       = '0;
        w_data       = '0;
        case (r_state)
            ST_IDLE: begin
                // A full FIFO holds off rename so queued commits get the port.
                w_disp_rdy = !flush_req && (w_fifo_count != CW'(COMMIT_DEPTH));
                if (dispatch_valid && w_disp_rdy) begin
                    if (dispatch_addr != '0) begin
                        w_en     = 1'b1;
                        w_is_ref = 1'b1;
                        w_addr   = dispatch_addr;
                        w_data   = DATA_WIDTH'(dispatch_rob_id);
                    end
                end else if (!w_fifo_empty) begin
                    w_pop  = 1'b1;
                    w_en   = 1'b1;
                    w_addr = w_head_addr;
                    w_data = w_head_data;
                end
                if (flush_req) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!w_fifo_empty) begin
                    w_pop  = 1'b1;
                    w_en   = 1'b1;
                    w_addr = w_head_addr;
                    w_data = w_head_data;
                end else begin
                    w_state_next = ST_WALK;
                    w_idx_next   = REG_ADDR_WIDTH'(1);
                end
            end
            ST_WALK: begin
                w_en      = 1'b1;
                w_restore = 1'b1;
                w_addr    = r_idx;
                if (r_idx == LAST_IDX) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = REG_ADDR_WIDTH'(1);
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = REG_ADDR_WIDTH'(1);
            end
        endcase
    end

    // Every output is forced low while reset is held, whatever the stale state.
    assign commit_ready     = !rst && !w_fifo_full;
    assign dispatch_ready   = !rst && w_disp_rdy;
    assign flush_busy       = !rst && (r_state != ST_IDLE);
    assign rf_write_en      = !rst && w_en;
    assign rf_write_restore = !rst && w_restore;
    assign rf_write_is_ref  = !rst && w_is_ref;
    assign rf_write_addr    = rst ? '0 : w_addr;
    assign rf_write_data    = rst ? '0 : w_data;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed self-checking bench for regfile_write_ctrl with hand-computed expectations.
module tb_regfile_write_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush_req, commit_valid, dispatch_valid;
    logic [4:0]  commit_addr, dispatch_addr;
    logic [31:0] commit_data;
    logic [3:0]  dispatch_rob_id;
    logic        flush_busy, commit_ready, dispatch_ready;
    logic        rf_write_en, rf_write_restore, rf_write_is_ref;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_write_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .flush_req        (flush_req),
        .flush_busy       (flush_busy),
        .commit_valid     (commit_valid),
        .commit_ready     (commit_ready),
        .commit_addr      (commit_addr),
        .commit_data      (commit_data),
        .dispatch_valid   (dispatch_valid),
        .dispatch_ready   (dispatch_ready),
        .dispatch_addr    (dispatch_addr),
        .dispatch_rob_id  (dispatch_rob_id),
        .rf_write_en      (rf_write_en),
        .rf_write_addr    (rf_write_addr),
        .rf_write_restore (rf_write_restore),
        .rf_write_is_ref  (rf_write_is_ref),
        .rf_write_data    (rf_write_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic en, input logic [4:0] a,
                          input logic rs, input logic ir, input logic [31:0] d);
        chk(tag, 64'({rf_write_en, rf_write_addr, rf_write_restore, rf_write_is_ref, rf_write_data}),
                 64'({en, a, rs, ir, d}));
    endtask

    task automatic chk_ctl(input string tag, input logic busy, input logic crdy, input logic drdy);
        chk(tag, 64'({flush_busy, commit_ready, dispatch_ready}), 64'({busy, crdy, drdy}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        flush_req       = 1'b0;
        commit_valid    = 1'b0;
        commit_addr     = '0;
        commit_data     = '0;
        dispatch_valid  = 1'b0;
        dispatch_addr   = '0;
        dispatch_rob_id = '0;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        commit_valid = 1'b1;
        commit_addr  = a;
        commit_data  = d;
    endtask

    task automatic disp(input logic [4:0] a, input logic [3:0] id);
        dispatch_valid  = 1'b1;
        dispatch_addr   = a;
        dispatch_rob_id = id;
    endtask

    initial begin
        // Reset: outputs forced low even with requests present
        rst = 1'b1;
        idle_inputs();
        push(5'd2, 32'h1);
        disp(5'd2, 4'd1);
        settle();
        chk_rf("rst_rf", 0, 0, 0, 0, 0);
        chk_ctl("rst_ctl", 0, 0, 0);
        tick();
        chk_rf("rst_rf2", 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        idle_inputs();
        settle();
        chk_ctl("post_rst_ctl", 0, 1, 1);
        chk_rf("post_rst_rf", 0, 0, 0, 0, 0);
        tick();

        // Dispatch wins immediately
        disp(5'd5, 4'd3);
        settle();
        chk_ctl("disp_ctl", 0, 1, 1);
        chk_rf("disp_rf", 1, 5'd5, 0, 1, 32'd3);
        tick();

        // Commit visible the cycle after enqueue
        idle_inputs();
        push(5'd7, 32'hDEAD);
        settle();
        chk_rf("commit_n", 0, 0, 0, 0, 0);
        tick();
        idle_inputs();
        settle();
        chk_rf("commit_n1", 1, 5'd7, 0, 0, 32'hDEAD);
        tick();
        chk_rf("commit_empty", 0, 0, 0, 0, 0);

        // Four commits under continuous dispatch
        disp(5'd9, 4'd6);
        for (int k = 0; k < 4; k++) begin
            push(5'(10 + k), 32'h100 + 32'(k));
            settle();
            chk_ctl($sformatf("fill%0d_ctl", k), 0, 1, 1);
            chk_rf($sformatf("fill%0d_rf", k), 1, 5'd9, 0, 1, 32'd6);
            tick();
        end
        commit_valid = 1'b0;
        settle();
        chk_ctl("full_ctl", 0, 0, 0);
        chk_rf("full_rf", 1, 5'd10, 0, 0, 32'h100);
        tick();
        dispatch_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            settle();
            chk_rf($sformatf("drain%0d", k), 1, 5'(10 + k), 0, 0, 32'h100 + 32'(k));
            tick();
        end
        chk_rf("drained_empty", 0, 0, 0, 0, 0);

        // Flush with two queued commits
        disp(5'd9, 4'd6);
        push(5'd20, 32'h20);
        settle();
        tick();
        push(5'd21, 32'h21);
        settle();
        chk_rf("pre_flush_disp", 1, 5'd9, 0, 1, 32'd6);
        tick();
        commit_valid = 1'b0;
        flush_req    = 1'b1;
        settle();
        chk_ctl("flush_cyc_ctl", 0, 1, 0);
        chk_rf("flush_cyc_rf", 1, 5'd20, 0, 0, 32'h20);
        tick();
        flush_req = 1'b0;
        settle();
        chk_ctl("drain_ctl", 1, 1, 0);
        chk_rf("drain_rf", 1, 5'd21, 0, 0, 32'h21);
        tick();
        chk_ctl("drain_idle_ctl", 1, 1, 0);
        chk_rf("drain_idle_rf", 0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= 31; i++) begin
            commit_valid = 1'b0;
            if (i == 5) push(5'd3, 32'h33);
            settle();
            chk_ctl($sformatf("walk%0d_ctl", i), 1, 1, 0);
            chk_rf($sformatf("walk%0d_rf", i), 1, 5'(i), 1, 0, 0);
            tick();
        end
        idle_inputs();
        settle();
        chk_ctl("walk_end_ctl", 0, 1, 1);
        chk_rf("walk_end_rf", 1, 5'd3, 0, 0, 32'h33);
        tick();
        chk_rf("walk_end_empty", 0, 0, 0, 0, 0);

        // Reset in the middle of a walk discards everything
        flush_req = 1'b1;
        settle();
        chk_rf("f2_req_rf", 0, 0, 0, 0, 0);
        tick();
        flush_req = 1'b0;
        settle();
        chk_ctl("f2_drain_ctl", 1, 1, 0);
        tick();
        for (int i = 1; i <= 12; i++) begin
            commit_valid = 1'b0;
            if (i == 3) push(5'd4, 32'h44);
            settle();
            chk_rf($sformatf("w2_%0d_rf", i), 1, 5'(i), 1, 0, 0);
            tick();
        end
        commit_valid = 1'b0;
        rst = 1'b1;
        settle();
        chk_rf("midwalk_rst_rf", 0, 0, 0, 0, 0);
        chk_ctl("midwalk_rst_ctl", 0, 0, 0);
        tick();
        rst = 1'b0;
        settle();
        chk_ctl("after_rst_ctl", 0, 1, 1);
        chk_rf("after_rst_rf", 0, 0, 0, 0, 0);
        tick();
        chk_rf("after_rst_rf2", 0, 0, 0, 0, 0);

        // Dispatch to r0 handshakes without a write
        disp(5'd0, 4'd7);
        settle();
        chk_ctl("r0_ctl", 0, 1, 1);
        chk_rf("r0_rf", 0, 0, 0, 0, 0);
        tick();

        // Repeated flush_req during the walk is ignored
        idle_inputs();
        flush_req = 1'b1;
        settle();
        tick();
        flush_req = 1'b0;
        settle();
        chk_rf("f3_drain_rf", 0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= 31; i++) begin
            flush_req = (i == 10);
            settle();
            chk_rf($sformatf("w3_%0d_rf", i), 1, 5'(i), 1, 0, 0);
            tick();
        end
        flush_req = 1'b0;
        settle();
        chk_ctl("w3_end_ctl", 0, 1, 1);
        chk_rf("w3_end_rf", 0, 0, 0, 0, 0);
        tick();
        chk_ctl("w3_no_restart_ctl", 0, 1, 1);
        chk_rf("w3_no_restart_rf", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
